// File: rtl/text_console_pkg.sv
// Shared constants and types for the text console writer: control codes, blank fill, FSM and cursor op encodings.
package text_console_pkg;

   localparam logic [7:0] CH_BS = 8'h08;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_FF = 8'h0C;
   localparam logic [7:0] CH_CR = 8'h0D;

   localparam logic [7:0] BLANK_CHAR_DEFAULT = 8'h20;

   typedef enum logic [1:0] {
      ST_CLEAR_ALL,
      ST_IDLE,
      ST_CLEAR_ROW
   } state_e;

   typedef enum logic [2:0] {
      CUR_NOP,
      CUR_PRINT,
      CUR_CR,
      CUR_LF,
      CUR_BS,
      CUR_HOME
   } cur_op_e;

endpackage

// File: rtl/text_cursor.sv
// Cursor column/row and scroll base counters; a line advance is flagged combinationally from the requested op.
// Scrolling of the base row is compiled in only with TEXT_CONSOLE_SCROLL_EN.
module text_cursor
   import text_console_pkg::*;
#(
   parameter int COLS     = 32,
   parameter int ROWS     = 32,
   parameter int VIS_ROWS = 30
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  cur_op_e                   i_op,
   output logic [$clog2(COLS)-1:0]   o_col,
   output logic [$clog2(ROWS)-1:0]   o_row,
   output logic [$clog2(ROWS)-1:0]   o_base,
   output logic                      o_line_adv
);

   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);
   localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
   localparam logic [RW-1:0] VIS_LAST = RW'(VIS_ROWS - 1);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [RW-1:0] base_q, base_d;

   assign o_line_adv = (i_op == CUR_LF) || ((i_op == CUR_PRINT) && (col_q == COL_LAST));

   always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      base_d = base_q;
      case (i_op)
         CUR_PRINT: col_d = col_q + 1'b1;
         CUR_CR,
         CUR_LF:    col_d = '0;
         CUR_BS:    if (col_q != '0) col_d = col_q - 1'b1;
         CUR_HOME: begin
            col_d  = '0;
            row_d  = '0;
            base_d = '0;
         end
         default: ;
      endcase
      // Row index wraps naturally because ROWS is a power of two.
      if (o_line_adv) row_d = row_q + 1'b1;
`ifdef TEXT_CONSOLE_SCROLL_EN
      if (o_line_adv && ((row_q - base_q) == VIS_LAST)) base_d = base_q + 1'b1;
`else
      base_d = '0;
`endif
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         col_q  <= '0;
         row_q  <= '0;
         base_q <= '0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         base_q <= base_d;
      end
   end

   assign o_col  = col_q;
   assign o_row  = row_q;
   assign o_base = base_q;

endmodule

// File: rtl/text_console_writer.sv
// Character stream to text-buffer writer: printable codes write with 1-cycle latency, line advances and FF clear via FSM.
// Accepts only in IDLE (o_ready); optional scrolling with macro TEXT_CONSOLE_SCROLL_EN.
module text_console_writer
   import text_console_pkg::*;
#(
   parameter int         COLS       = 32,
   parameter int         ROWS       = 32,
   parameter int         VIS_ROWS   = 30,
   parameter logic [7:0] BLANK_CHAR = BLANK_CHAR_DEFAULT
) (
   input  logic                                   i_pix_clk,
   input  logic                                   i_reset,
   input  logic [7:0]                             i_char,
   input  logic                                   i_valid,
   output logic                                   o_ready,
   output logic                                   o_wr_en,
   output logic [$clog2(ROWS)+$clog2(COLS)-1:0]   o_wr_addr,
   output logic [7:0]                             o_wr_data,
   output logic [15:0]                            o_scroll_y,
   output logic [$clog2(COLS)-1:0]                o_cursor_col,
   output logic [$clog2(ROWS)-1:0]                o_cursor_row
);

   localparam int CW     = $clog2(COLS);
   localparam int RW     = $clog2(ROWS);
   localparam int ADDR_W = RW + CW;
   localparam logic [CW-1:0]     COL_LAST = CW'(COLS - 1);
   localparam logic [ADDR_W-1:0] ALL_LAST = ADDR_W'(ROWS * COLS - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          data_q, data_d;

   cur_op_e             cur_op;
   logic [CW-1:0]       cur_col;
   logic [RW-1:0]       cur_row;
   logic [RW-1:0]       base_row;
   logic                line_adv;
   logic                accept;

   assign o_ready = (state_q == ST_IDLE);
   assign accept  = i_valid && o_ready;

   always_comb begin
      cur_op = CUR_NOP;
      if (accept) begin
         case (i_char)
            CH_CR:   cur_op = CUR_CR;
            CH_LF:   cur_op = CUR_LF;
            CH_BS:   cur_op = CUR_BS;
            CH_FF:   cur_op = CUR_HOME;
            default: cur_op = CUR_PRINT;
         endcase
      end
   end

   text_cursor #(
      .COLS     (COLS),
      .ROWS     (ROWS),
      .VIS_ROWS (VIS_ROWS)
   ) u_cursor (
      .i_clk      (i_pix_clk),
      .i_reset    (i_reset),
      .i_op       (cur_op),
      .o_col      (cur_col),
      .o_row      (cur_row),
      .o_base     (base_row),
      .o_line_adv (line_adv)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_en_d = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         ST_CLEAR_ALL: begin
            wr_en_d = 1'b1;
            addr_d  = cnt_q;
            data_d  = BLANK_CHAR;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == ALL_LAST) state_d = ST_IDLE;
         end
         ST_CLEAR_ROW: begin
            // cur_row has already advanced to the row being cleared.
            wr_en_d = 1'b1;
            addr_d  = {cur_row, cnt_q[CW-1:0]};
            data_d  = BLANK_CHAR;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q[CW-1:0] == COL_LAST) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            case (cur_op)
               CUR_PRINT: begin
                  wr_en_d = 1'b1;
                  addr_d  = {cur_row, cur_col};
                  data_d  = i_char;
               end
               CUR_BS: begin
                  if (cur_col != '0) begin
                     wr_en_d = 1'b1;
                     addr_d  = {cur_row, cur_col - 1'b1};
                     data_d  = BLANK_CHAR;
                  end
               end
               CUR_HOME: begin
                  state_d = ST_CLEAR_ALL;
                  cnt_d   = '0;
               end
               default: ;
            endcase
            if (line_adv) begin
               state_d = ST_CLEAR_ROW;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_CLEAR_ALL;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge i_pix_clk) begin
      if (i_reset) begin
         state_q <= ST_CLEAR_ALL;
         cnt_q   <= '0;
         wr_en_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= BLANK_CHAR;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_en_q <= wr_en_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign o_wr_en      = wr_en_q;
   assign o_wr_addr    = addr_q;
   assign o_wr_data    = data_q;
   assign o_scroll_y   = 16'({base_row, 3'b000});
   assign o_cursor_col = cur_col;
   assign o_cursor_row = cur_row;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: reset clear, printing, wrap, BS, LF scrolling, FF with reset abort.
module tb_text_console_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  ch;
   logic        valid;
   logic        ready;
   logic        wr_en;
   logic [9:0]  wr_addr;
   logic [7:0]  wr_data;
   logic [15:0] scroll_y;
   logic [4:0]  cur_col;
   logic [4:0]  cur_row;

   int n_assert = 0;
   int n_fail   = 0;
   int k;

   logic [17:0] wq[$];

`ifdef TEXT_CONSOLE_SCROLL_EN
   localparam int EXP_SCROLL_30 = 8;
   localparam int EXP_SCROLL_32 = 24;
`else
   localparam int EXP_SCROLL_30 = 0;
   localparam int EXP_SCROLL_32 = 0;
`endif

   always #5 clk = ~clk;

   text_console_writer dut (
      .i_pix_clk    (clk),
      .i_reset      (rst),
      .i_char       (ch),
      .i_valid      (valid),
      .o_ready      (ready),
      .o_wr_en      (wr_en),
      .o_wr_addr    (wr_addr),
      .o_wr_data    (wr_data),
      .o_scroll_y   (scroll_y),
      .o_cursor_col (cur_col),
      .o_cursor_row (cur_row)
   );

   always @(negedge clk) if (wr_en === 1'b1) wq.push_back({wr_addr, wr_data});

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(output int cnt);
      cnt = 0;
      while (ready !== 1'b1 && cnt < 2000) begin
         tick(1);
         cnt++;
      end
   endtask

   task automatic send(input logic [7:0] c);
      int w;
      wait_ready(w);
      check("send_ready", {31'd0, ready}, 32'd1);
      valid = 1'b1;
      ch    = c;
      tick(1);
      valid = 1'b0;
   endtask

   function automatic int bad_blank(input int base, input int n);
      int bad = 0;
      for (int i = 0; i < n; i++) begin
         logic [9:0] a;
         a = 10'(base + i);
         if (i >= wq.size() || wq[i] !== {a, 8'h20}) bad++;
      end
      return bad;
   endfunction

   initial begin
      rst   = 1'b1;
      valid = 1'b0;
      ch    = 8'h00;
      tick(3);
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_wr_en", {31'd0, wr_en}, 32'd0);
      check("rst_wr_data", {24'd0, wr_data}, 32'h20);
      check("rst_scroll", {16'd0, scroll_y}, 32'd0);
      check("rst_cursor", {22'd0, cur_row, cur_col}, 32'd0);

      wq.delete();
      rst = 1'b0;
      k = 0;
      while (ready !== 1'b1 && k < 2000) begin
         tick(1);
         k++;
      end
      check("init_ready_cycles", k, 32'd1024);
      check("init_write_count", wq.size(), 32'd1024);
      check("init_write_bad", bad_blank(0, 1024), 32'd0);

      wq.delete();
      send(8'h48);
      send(8'h69);
      tick(1);
      check("hi_count", wq.size(), 32'd2);
      check("hi_w0", {14'd0, wq[0]}, {14'd0, 10'h000, 8'h48});
      check("hi_w1", {14'd0, wq[1]}, {14'd0, 10'h001, 8'h69});
      check("hi_cursor", {22'd0, cur_row, cur_col}, {22'd0, 5'd0, 5'd2});

      wq.delete();
      send(8'h0D);
      tick(2);
      check("cr_nowrite", wq.size(), 32'd0);
      check("cr_col", {27'd0, cur_col}, 32'd0);

      for (int i = 0; i < 32; i++) send(8'h41);
      k = 0;
      while (ready !== 1'b1 && k < 2000) begin
         tick(1);
         k++;
      end
      check("wrap_ready_low", k, 32'd32);
      check("wrap_count", wq.size(), 32'd64);
      begin
         int bad = 0;
         for (int i = 0; i < 32; i++)
            if (wq[i] !== {10'(i), 8'h41}) bad++;
         check("wrap_chars_bad", bad, 32'd0);
      end
      begin
         logic [17:0] tail[$];
         tail = wq[32:63];
         wq   = tail;
      end
      check("wrap_clear_bad", bad_blank(32, 32), 32'd0);
      check("wrap_cursor", {22'd0, cur_row, cur_col}, {22'd0, 5'd1, 5'd0});

      send(8'h0C);
      wait_ready(k);
      check("ff_home", {22'd0, cur_row, cur_col}, 32'd0);
      for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
      check("bs_pre_col", {27'd0, cur_col}, 32'd5);
      wq.delete();
      send(8'h08);
      tick(1);
      check("bs_count", wq.size(), 32'd1);
      check("bs_write", {14'd0, wq[0]}, {14'd0, 10'h004, 8'h20});
      check("bs_col", {27'd0, cur_col}, 32'd4);
      send(8'h0D);
      wq.delete();
      send(8'h08);
      tick(2);
      check("bs0_nowrite", wq.size(), 32'd0);
      check("bs0_col", {27'd0, cur_col}, 32'd0);

      for (int i = 0; i < 29; i++) send(8'h0A);
      wait_ready(k);
      check("lf29_row", {27'd0, cur_row}, 32'd29);
      wq.delete();
      send(8'h0A);
      k = 0;
      while (ready !== 1'b1 && k < 2000) begin
         tick(1);
         k++;
      end
      check("lf30_ready_low", k, 32'd32);
      check("lf30_row", {27'd0, cur_row}, 32'd30);
      check("lf30_scroll", {16'd0, scroll_y}, EXP_SCROLL_30);
      check("lf30_clear_count", wq.size(), 32'd32);
      check("lf30_clear_bad", bad_blank(10'h3C0, 32), 32'd0);
      send(8'h0A);
      send(8'h0A);
      wait_ready(k);
      check("lf32_row_wrap", {27'd0, cur_row}, 32'd0);
      check("lf32_scroll", {16'd0, scroll_y}, EXP_SCROLL_32);

      send(8'h58);
      send(8'h59);
      send(8'h0C);
      valid = 1'b1;
      ch    = 8'h5A;
      wq.delete();
      tick(10);
      check("ff_partial_count", wq.size(), 32'd10);
      check("ff_partial_last", {14'd0, wq[wq.size()-1]}, {14'd0, 10'h009, 8'h20});
      rst = 1'b1;
      tick(1);
      check("abort_wr_en", {31'd0, wr_en}, 32'd0);
      check("abort_ready", {31'd0, ready}, 32'd0);
      tick(2);
      wq.delete();
      rst = 1'b0;
      k = 0;
      while (ready !== 1'b1 && k < 2000) begin
         tick(1);
         k++;
      end
      valid = 1'b0;
      check("abort_ready_cycles", k, 32'd1024);
      check("abort_write_count", wq.size(), 32'd1024);
      check("abort_write_bad", bad_blank(0, 1024), 32'd0);
      check("abort_cursor", {22'd0, cur_row, cur_col}, 32'd0);
      tick(2);
      check("idle_wr_en", {31'd0, wr_en}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/text_console_writer.md
TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 Parameter COLS, default 32, meaning text columns; power of two; address column field width is log2(COLS).
REQ-002 Parameter ROWS, default 32, meaning physical text-buffer rows; power of two.
REQ-003 Parameter VIS_ROWS, default 30, meaning rows visible on a 480-line display.
REQ-004 Parameter BLANK_CHAR, default 8'h20, meaning the code written when a cell is cleared.
REQ-005 i_pix_clk  in  1  clock; one clock domain; all logic on its rising edge.
REQ-006 i_reset  in  1  reset; synchronous, active-high.
REQ-007 i_char  in  8  character or control code.
REQ-008 i_valid  in  1  i_char is valid.
REQ-009 o_ready  out  1  block accepts i_char this cycle.
REQ-010 o_wr_en  out  1  text-buffer write strobe.
REQ-011 o_wr_addr  out  10  write address {row[4:0], col[4:0]}; this is the same layout the tile renderer reads.
REQ-012 o_wr_data  out  8  write data.
REQ-013 o_scroll_y  out  16  pixel scroll for the renderer's i_offset_y, equal to {base_row, 3'b000}.
REQ-014 o_cursor_col / o_cursor_row  out  5 / 5  physical cursor position.

Function
REQ-015 Handshake: a character is accepted when i_valid and o_ready are both high on the same edge; o_ready is high only in IDLE.
REQ-016 States: CLEAR_ALL, IDLE, CLEAR_ROW; no other states.
REQ-017 Printable codes are every code except 0x08, 0x0A, 0x0C and 0x0D.
REQ-018 A printable code drives o_wr_en=1, o_wr_addr={cur_row, cur_col} and o_wr_data=i_char on the cycle after acceptance (latency 1).
REQ-019 After a printable code, cur_col increments; at col COLS-1 the column wraps to 0 and a line advance occurs.
REQ-020 0x0D (CR): cur_col=0; no write.
REQ-021 0x0A (LF): cur_col=0 and a line advance occurs.
REQ-022 0x08 (BS): if cur_col>0, cur_col decrements and BLANK_CHAR is written at the new position with 1-cycle latency; at col 0 it does nothing.
REQ-023 0x0C (FF): cursor goes to (0,0), base_row=0, and the block enters CLEAR_ALL.
REQ-024 Line advance: cur_row = (cur_row+1) mod ROWS, then enter CLEAR_ROW for that row.
REQ-025 CLEAR_ROW writes BLANK_CHAR to cols 0..COLS-1, one per cycle, then returns to IDLE; o_ready is low for COLS cycles.
REQ-026 CLEAR_ALL writes BLANK_CHAR to addresses 0..1023 ascending, one per cycle, then returns to IDLE.
REQ-027 o_wr_en is low in IDLE except for the single write cycle that follows acceptance of a printable code or BS.
REQ-028 i_valid is ignored while o_ready is low; characters arriving then are neither accepted nor queued.

Reset
REQ-029 i_reset: the block enters CLEAR_ALL; cursor=(0,0), base_row=0, o_ready=0, o_wr_en=0, o_wr_data=BLANK_CHAR, o_scroll_y=0.
REQ-030 Reset asserted mid-clear or mid-write aborts the operation on that edge and restarts CLEAR_ALL from address 0.
REQ-031 o_ready first rises 1024 cycles after reset deasserts.

Configuration
REQ-032 Macro TEXT_CONSOLE_SCROLL_EN.
REQ-033 Defined: on a line advance where (cur_row - base_row) mod ROWS == VIS_ROWS-1, base_row increments mod ROWS on the same edge, and the newly cleared row appears at the bottom.
REQ-034 Not defined: base_row is held at 0, o_scroll_y is tied to 0, and the cursor row wraps from ROWS-1 to 0.

Structure
REQ-035 Package text_console_pkg holds the control-code constants (CH_BS, CH_LF, CH_FF, CH_CR), BLANK_CHAR_DEFAULT, and the state enum.
REQ-036 Sub-module text_cursor holds the cur_col/cur_row/base_row counters and the advance and scroll logic; the FSM and write mux live in the top.

Verification
REQ-037 Reset, then wait: exactly 1024 writes of 0x20 occur at addresses 0..1023; o_ready rises on cycle 1024.
REQ-038 Send 'H' (0x48) then 'i' (0x69): writes of 0x48@0x000 and 0x69@0x001; cursor ends at (0,2).
REQ-039 Send 32 'A' (0x41): writes @0x000..0x01F, then 32 writes of 0x20 @0x020..0x03F; cursor ends at (1,0).
REQ-040 At (0,5), send BS: 0x20 is written @0x004; a second BS at col 0 produces no write.
REQ-041 With SCROLL_EN, send 30 LFs: after the 30th LF, base_row=1, o_scroll_y=8, and row 30 is cleared; without SCROLL_EN, o_scroll_y stays 0.
REQ-042 Send FF mid-line, then assert i_reset 10 cycles into the clear: CLEAR_ALL restarts at 0x000, and i_valid held high throughout is not accepted.
